mac_result_drain: RTL and testbench
===================================

# mac_result_drain

Reader/drain end of the MAC array's result interface. Captures per-lane accumulator results as each lane's `valid_out` bit fires. Returns a one-cycle clear pulse to the captured lane. Serializes captured results onto a single valid/ready output stream tagged with the lane index, and sits between `mac_array` and the downstream result memory/writeback path.

## Interface
Parameters:
- `ACC_W`, 16, accumulator/result width
- `N_MACS`, 4, number of MAC lanes; lane index width `LW = $clog2(N_MACS)` is a derived localparam

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `acc_in`  in  N_MACS*ACC_W  flat lane results; lane i at `[i*ACC_W +: ACC_W]`, signed
- `valid_in`  in  N_MACS  per-lane result-valid from the MAC array
- `mac_clear`  out  N_MACS  one-cycle clear pulse to lane i after its result is captured
- `out_data`  out  ACC_W  serialized result, signed
- `out_lane`  out  LW  lane index of `out_data`
- `out_last`  out  1  no other lane pending when this word was loaded
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts
- `overflow`  out  1  sticky; a result was dropped
- `clr_overflow`  in  1  clears `overflow`
- `busy`  out  1  `|pending | out_valid`

## Operation
- Per lane: holding register `hold[i]` and flag `pending[i]`.
- Capture (lane i, cycle t): `valid_in[i]=1` and (`pending[i]=0` or lane i is loaded into the output register in cycle t).
  - Effect: `hold[i] <= acc_in` lane i and `pending[i] <= 1`.
  - `mac_clear[i]=1` in cycle t+1 only.
- Drop: `valid_in[i]=1`, `pending[i]=1`, and lane i is not loaded in cycle t.
  - Effect: the new value is discarded, `hold[i]` is unchanged, `overflow <= 1`, and no `mac_clear`.
- Output register load: occurs when `(!out_valid || out_ready)` and `|pending`.
  - Lane selection is round-robin: the first pending lane at or after `rr_ptr`, wrapping N_MACS-1→0.
  - On load: `out_data <= hold[sel]`, `out_lane <= sel`, `pending[sel] <= 0` (unless recaptured the same cycle), `rr_ptr <= sel+1` (wrapping).
  - `out_last <= 1` iff no other lane has `pending=1` in the load cycle; same-cycle captures are ignored.
- When `out_ready=1` and nothing is pending, `out_valid <= 0`.
- Drain FSM:
  - IDLE (`out_valid=0`) → HOLD on load.
  - HOLD → HOLD on handshake with another load, or while stalled.
  - HOLD → IDLE on handshake with nothing pending.
- Handshake: transfer occurs when `out_valid && out_ready`. While `out_valid && !out_ready`, `out_data`/`out_lane`/`out_last` are held stable.
- `clr_overflow` clears `overflow`; if a drop occurs in the same cycle, set wins.
- No arithmetic; data is passed through unmodified at full ACC_W.

## Timing
- Reset values: `out_valid`, `out_data`, `out_lane`, `out_last`, `mac_clear`, `overflow`, `busy`, all `pending` = 0; `rr_ptr` = 0.
- Reset mid-operation discards all held data immediately; no clear pulses are issued.
- Capture latency: `valid_in[i]` at cycle t → `pending[i]` and `mac_clear[i]` at t+1 → earliest `out_valid` at t+2.
- With `out_ready` held high, throughput is one word per cycle. N simultaneous captures drain in N consecutive cycles, starting t+2.
- Same-cycle load and capture of the same lane: the old value goes out and the new value stays pending; no overflow.
- All outputs are registered; there is no combinational path from `out_ready` or `valid_in` to any output.

## Structure
- Shared package `mac_pkg`: `ACC_W`/`N_MACS` defaults, `lane_idx_t` typedef (`LW` bits), drain-state enum {IDLE, HOLD}.
- Sub-module `rr_lane_arbiter`: combinational round-robin pick.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: `sel` index, `any`, `others_pending` flag (used for `out_last`).

## Test plan
- Single result: `valid_in=4'b0010`, lane 1 = 16'sh00A5, `out_ready=1`.
  - Required: `mac_clear=4'b0010` at t+1; `out_valid` at t+2 with data 0x00A5, lane 1, `out_last=1`; idle at t+3; `busy` low at t+3.
- All lanes: lanes = 1, -2, 3, -4, all valid in one cycle, `out_ready` toggling 1,0,1,0.
  - Required: words emitted in lane order 0,1,2,3.
  - Required: data is held stable on stall cycles.
  - Required: `out_last` set only on lane 3.
- Overflow: lane 2 captured 7 with `out_ready=0` and lane 0 occupying the output; then lane 2 valid again with 9.
  - Required: `overflow=1` and no second `mac_clear[2]`.
  - Required: 7 is delivered and 9 is never delivered.
  - Required: `clr_overflow` clears `overflow`.
- Recapture on load: lane 3 pending with 5, loaded in the same cycle as `valid_in[3]` with 6.
  - Required: 5 is output, then 6; `overflow` stays 0.
- Fairness: lanes 0 and 1 re-assert valid every cycle, lanes 2 and 3 once.
  - Required: lanes 2 and 3 are each output within 4 words of capture.
- Reset mid-op: assert `rst` while `out_valid=1` with 2 lanes pending.
  - Required: all outputs 0 asynchronously; no words emitted after release until new `valid_in`.

Source files
------------

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC array result path.
//   ACC_W_DEFAULT  : default accumulator/result width
//   N_MACS_DEFAULT : default number of MAC lanes
//   lane_idx_t     : lane index type for the default lane count
//   drain_state_t  : output drain state (IDLE = no word held, HOLD = word held)
//   next_lane()    : round-robin successor of a lane index
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int ACC_W_DEFAULT  = 16;
  localparam int N_MACS_DEFAULT = 4;
  localparam int LW_DEFAULT     = (N_MACS_DEFAULT > 1) ? $clog2(N_MACS_DEFAULT) : 1;

  typedef logic [LW_DEFAULT-1:0] lane_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_t;

  // Successor of lane cur in a ring of n lanes.
  function automatic int next_lane(input int cur, input int n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_lane_arbiter.sv
// ---------------------------------------------------------------------------
// rr_lane_arbiter
// Combinational round-robin lane pick.
//   i_req            : per-lane request (pending) vector
//   i_ptr            : lane with highest priority this cycle
//   o_sel            : first requesting lane at or after i_ptr, wrapping
//   o_any            : at least one lane is requesting
//   o_othersPending  : a lane other than o_sel is requesting
// ---------------------------------------------------------------------------
module rr_lane_arbiter #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_ptr,
  output logic [LW-1:0] o_sel,
  output logic          o_any,
  output logic          o_othersPending
);

  logic [N-1:0] w_selMask;
  logic         w_found;

  // Walk the ring starting at the pointer and keep the first requester.
  always_comb begin
    int idx;
    o_sel   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[idx]) begin
        o_sel   = LW'(idx);
        w_found = 1'b1;
      end
    end
  end

  // Anything still requesting once the chosen lane is masked out.
  always_comb begin
    w_selMask        = '0;
    w_selMask[o_sel] = 1'b1;
    o_othersPending  = |(i_req & ~w_selMask);
    o_any            = |i_req;
  end

endmodule

// File: rtl/mac_result_drain.sv
// ---------------------------------------------------------------------------
// mac_result_drain
// Captures per-lane MAC results, pulses a clear back to each captured lane and
// serialises the held results onto one valid/ready stream tagged by lane.
//   clk, rst      : clock, asynchronous active-high reset
//   acc_in        : flat lane results, lane i at [i*ACC_W +: ACC_W]
//   valid_in      : per-lane result valid
//   mac_clear     : one-cycle clear pulse to each lane captured last cycle
//   out_data      : serialised result word
//   out_lane      : lane index of out_data
//   out_last      : no other lane was pending when this word was loaded
//   out_valid     : output word valid
//   out_ready     : downstream accepts
//   overflow      : sticky, a result was dropped
//   clr_overflow  : clears overflow (a same-cycle drop wins)
//   busy          : results pending or output word held
// ---------------------------------------------------------------------------
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int N_MACS = N_MACS_DEFAULT,
  localparam int LW    = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MACS*ACC_W-1:0] acc_in,
  input  logic [N_MACS-1:0]       valid_in,
  output logic [N_MACS-1:0]       mac_clear,
  output logic [ACC_W-1:0]        out_data,
  output logic [LW-1:0]           out_lane,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    clr_overflow,
  output logic                    busy
);

  logic [ACC_W-1:0]  r_hold [N_MACS];
  logic [N_MACS-1:0] r_pending;
  logic [N_MACS-1:0] r_macClear;
  logic [LW-1:0]     r_rrPtr;
  logic              r_overflow;
  drain_state_t      r_state;
  logic [ACC_W-1:0]  r_outData;
  logic [LW-1:0]     r_outLane;
  logic              r_outLast;

  logic [LW-1:0]     w_sel;
  logic              w_any;
  logic              w_othersPending;
  logic              w_load;
  logic [N_MACS-1:0] w_loadMask;
  logic [N_MACS-1:0] w_capture;
  logic [N_MACS-1:0] w_drop;

  rr_lane_arbiter #(
    .N  (N_MACS),
    .LW (LW)
  ) u_arb (
    .i_req           (r_pending),
    .i_ptr           (r_rrPtr),
    .o_sel           (w_sel),
    .o_any           (w_any),
    .o_othersPending (w_othersPending)
  );

  // A new word can enter the output register when it is empty or being
  // accepted this cycle, provided some lane has a result waiting.
  assign w_load = ((r_state == IDLE) || out_ready) && w_any;

  // A lane being loaded frees its holding register in the same cycle, so a
  // fresh result for that lane is captured rather than dropped.
  always_comb begin
    w_loadMask = '0;
    if (w_load) begin
      w_loadMask[w_sel] = 1'b1;
    end
    w_capture = valid_in & (~r_pending | w_loadMask);
    w_drop    = valid_in & r_pending & ~w_loadMask;
  end

  // Per-lane holding registers, pending flags and the clear pulse back to
  // the MAC array. Reset discards everything without issuing clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MACS; i++) begin
        r_hold[i] <= '0;
      end
      r_pending  <= '0;
      r_macClear <= '0;
    end else begin
      for (int i = 0; i < N_MACS; i++) begin
        if (w_capture[i]) begin
          r_hold[i] <= acc_in[i*ACC_W +: ACC_W];
        end
      end
      r_pending  <= w_capture | (r_pending & ~w_loadMask);
      r_macClear <= w_capture;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear request wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Drain FSM and output register. In HOLD a load implies the current word
  // was accepted; with no load, an accepted word empties the register and a
  // stalled word stays untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_outData <= '0;
      r_outLane <= '0;
      r_outLast <= 1'b0;
      r_rrPtr   <= '0;
    end else begin
      if (w_load) begin
        r_state   <= HOLD;
        r_outData <= r_hold[w_sel];
        r_outLane <= w_sel;
        r_outLast <= !w_othersPending;
        r_rrPtr   <= LW'(next_lane(int'(w_sel), N_MACS));
      end else if (r_state == HOLD && out_ready) begin
        r_state <= IDLE;
      end
    end
  end

  assign mac_clear = r_macClear;
  assign out_data  = r_outData;
  assign out_lane  = r_outLane;
  assign out_last  = r_outLast;
  assign out_valid = (r_state == HOLD);
  assign overflow  = r_overflow;
  assign busy      = (|r_pending) || (r_state == HOLD);

endmodule

// File: tb/tb_mac_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mac_result_drain
// Self-checking bench for mac_result_drain with the default 16-bit, 4-lane
// configuration: a table of directed vectors, hand-written corner sequences
// and randomised traffic checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_mac_result_drain;

  logic        clk;
  logic        rst;
  logic [63:0] acc_in;
  logic [3:0]  valid_in;
  logic [3:0]  mac_clear;
  logic [15:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clr_overflow;
  logic        busy;

  int testsRun;
  int testsFailed;

  mac_result_drain #(
    .ACC_W  (16),
    .N_MACS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .acc_in       (acc_in),
    .valid_in     (valid_in),
    .mac_clear    (mac_clear),
    .out_data     (out_data),
    .out_lane     (out_lane),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what is waiting per lane, what sits on the output, and
  // which lane has priority next.
  bit          mPend [4];
  logic [15:0] mHold [4];
  int          mPtr;
  bit          mValid;
  logic [15:0] mData;
  int          mLane;
  bit          mLast;
  bit          mOvf;
  logic [3:0]  mClear;

  task automatic modelReset();
    for (int l = 0; l < 4; l++) begin
      mPend[l] = 0;
      mHold[l] = '0;
    end
    mPtr = 0; mValid = 0; mData = '0; mLane = 0; mLast = 0; mOvf = 0; mClear = '0;
  endtask

  // One clock of the drain rules, evaluated from the pre-edge state.
  task automatic modelStep(input logic [3:0] vin, input logic [63:0] acc,
                           input logic ready, input logic clr);
    int  sel;
    int  others;
    bit  load;
    bit  drop;
    bit  nPend [4];
    logic [3:0] nClear;
    sel = -1;
    for (int k = 0; k < 4; k++) begin
      if (sel < 0 && mPend[(mPtr + k) % 4]) sel = (mPtr + k) % 4;
    end
    load = (sel >= 0) && (!mValid || ready);
    if (load) begin
      others = 0;
      for (int l = 0; l < 4; l++) if (l != sel && mPend[l]) others++;
      mData  = mHold[sel];
      mLane  = sel;
      mLast  = (others == 0);
      mValid = 1;
      mPtr   = (sel + 1) % 4;
    end else if (ready) begin
      mValid = 0;
    end
    drop   = 0;
    nClear = '0;
    for (int l = 0; l < 4; l++) begin
      nPend[l] = mPend[l] && !(load && sel == l);
      if (vin[l]) begin
        if (!nPend[l]) begin
          mHold[l]  = acc[l*16 +: 16];
          nPend[l]  = 1;
          nClear[l] = 1'b1;
        end else begin
          drop = 1;
        end
      end
    end
    for (int l = 0; l < 4; l++) mPend[l] = nPend[l];
    mClear = nClear;
    if (drop) mOvf = 1;
    else if (clr) mOvf = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and leave
  // the bench 1 ns after the edge, ready to sample.
  task automatic applyStimulus(input logic [3:0] vin, input logic [63:0] acc,
                               input logic ready, input logic clr);
    valid_in     = vin;
    acc_in       = acc;
    out_ready    = ready;
    clr_overflow = clr;
    @(posedge clk);
    modelStep(vin, acc, ready, clr);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eClear,
                             input logic eValid, input logic [15:0] eData,
                             input logic [1:0] eLane, input logic eLast,
                             input logic eOvf, input logic eBusy);
    logic [25:0] got;
    logic [25:0] exp;
    got = {mac_clear, out_valid, out_data, out_lane, out_last, overflow, busy};
    exp = {eClear, eValid, eData, eLane, eLast, eOvf, eBusy};
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got clr=%b v=%b d=%h lane=%0d last=%b ovf=%b busy=%b, required clr=%b v=%b d=%h lane=%0d last=%b ovf=%b busy=%b",
               name, mac_clear, out_valid, out_data, out_lane, out_last, overflow, busy,
               eClear, eValid, eData, eLane, eLast, eOvf, eBusy);
    end
  endtask

  task automatic checkModel(input string name);
    bit anyPend;
    anyPend = 0;
    for (int l = 0; l < 4; l++) anyPend |= mPend[l];
    checkOutput(name, mClear, mValid, mData, 2'(mLane), mLast, mOvf, anyPend || mValid);
  endtask

  task automatic doReset();
    valid_in = '0; acc_in = '0; out_ready = 1'b1; clr_overflow = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    string       name;
    logic [3:0]  vin;
    logic [63:0] acc;
    logic        ready;
    logic        clr;
    logic [3:0]  eClear;
    logic        eValid;
    logic [15:0] eData;
    logic [1:0]  eLane;
    logic        eLast;
    logic        eOvf;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input string name, input logic [3:0] vin, input logic [63:0] acc,
                        input logic ready, input logic clr, input logic [3:0] eClear,
                        input logic eValid, input logic [15:0] eData, input logic [1:0] eLane,
                        input logic eLast, input logic eOvf, input logic eBusy);
    vec_t v;
    v.name = name; v.vin = vin; v.acc = acc; v.ready = ready; v.clr = clr;
    v.eClear = eClear; v.eValid = eValid; v.eData = eData; v.eLane = eLane;
    v.eLast = eLast; v.eOvf = eOvf; v.eBusy = eBusy;
    vecs.push_back(v);
  endtask

  initial begin
    int pos2;
    int pos3;
    int words;
    logic [63:0] rAcc;

    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    valid_in = '0; acc_in = '0; out_ready = 1'b1; clr_overflow = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 0, 16'h0000, 2'd0, 0, 0, 0);
    rst = 1'b0;

    // Lanes 1,-2,3,-4 together, ready toggling; then a single lane-1 result;
    // then a drop on lane 2 while lane 0 is stalled on the output.
    addRow("all_cap",    4'b1111, 64'hFFFC_0003_FFFE_0001, 1, 0, 4'b1111, 0, 16'h0000, 2'd0, 0, 0, 1);
    addRow("all_w0",     4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'h0001, 2'd0, 0, 0, 1);
    addRow("all_stall0", 4'b0000, 64'h0,                   0, 0, 4'b0000, 1, 16'h0001, 2'd0, 0, 0, 1);
    addRow("all_w1",     4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'hFFFE, 2'd1, 0, 0, 1);
    addRow("all_stall1", 4'b0000, 64'h0,                   0, 0, 4'b0000, 1, 16'hFFFE, 2'd1, 0, 0, 1);
    addRow("all_w2",     4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'h0003, 2'd2, 0, 0, 1);
    addRow("all_stall2", 4'b0000, 64'h0,                   0, 0, 4'b0000, 1, 16'h0003, 2'd2, 0, 0, 1);
    addRow("all_w3",     4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'hFFFC, 2'd3, 1, 0, 1);
    addRow("all_idle",   4'b0000, 64'h0,                   1, 0, 4'b0000, 0, 16'hFFFC, 2'd3, 1, 0, 0);
    addRow("one_cap",    4'b0010, 64'h0000_0000_00A5_0000, 1, 0, 4'b0010, 0, 16'hFFFC, 2'd3, 1, 0, 1);
    addRow("one_out",    4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'h00A5, 2'd1, 1, 0, 1);
    addRow("one_idle",   4'b0000, 64'h0,                   1, 0, 4'b0000, 0, 16'h00A5, 2'd1, 1, 0, 0);
    addRow("ovf_lane0",  4'b0001, 64'h0000_0000_0000_0011, 0, 0, 4'b0001, 0, 16'h00A5, 2'd1, 1, 0, 1);
    addRow("ovf_cap7",   4'b0100, 64'h0000_0007_0000_0000, 0, 0, 4'b0100, 1, 16'h0011, 2'd0, 1, 0, 1);
    addRow("ovf_drop9",  4'b0100, 64'h0000_0009_0000_0000, 0, 0, 4'b0000, 1, 16'h0011, 2'd0, 1, 1, 1);
    addRow("ovf_out7",   4'b0000, 64'h0,                   1, 0, 4'b0000, 1, 16'h0007, 2'd2, 1, 1, 1);
    addRow("ovf_clear",  4'b0000, 64'h0,                   1, 1, 4'b0000, 0, 16'h0007, 2'd2, 1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].vin, vecs[i].acc, vecs[i].ready, vecs[i].clr);
      checkOutput(vecs[i].name, vecs[i].eClear, vecs[i].eValid, vecs[i].eData,
                  vecs[i].eLane, vecs[i].eLast, vecs[i].eOvf, vecs[i].eBusy);
    end

    // Lane 3 reloaded in the very cycle its old value is loaded out.
    doReset();
    applyStimulus(4'b1000, 64'h0005_0000_0000_0000, 1, 0);
    checkModel("recap_cap5");
    applyStimulus(4'b1000, 64'h0006_0000_0000_0000, 1, 0);
    checkOutput("recap_out5", 4'b1000, 1, 16'h0005, 2'd3, 1, 0, 1);
    applyStimulus(4'b0000, 64'h0, 1, 0);
    checkOutput("recap_out6", 4'b0000, 1, 16'h0006, 2'd3, 1, 0, 1);
    applyStimulus(4'b0000, 64'h0, 1, 0);
    checkOutput("recap_idle", 4'b0000, 0, 16'h0006, 2'd3, 1, 0, 0);

    // Lanes 0 and 1 hammer every cycle; lanes 2 and 3 fire once.
    pos2 = -1; pos3 = -1; words = 0;
    for (int c = 0; c < 12; c++) begin
      rAcc = {$urandom, $urandom};
      applyStimulus((c == 0) ? 4'b1111 : 4'b0011, rAcc, 1, 0);
      checkModel("fair_cycle");
      if (out_valid) begin
        words++;
        if (out_lane == 2'd2 && pos2 < 0) pos2 = words;
        if (out_lane == 2'd3 && pos3 < 0) pos3 = words;
      end
    end
    testsRun++;
    if (pos2 < 1 || pos2 > 4 || pos3 < 1 || pos3 > 4) begin
      testsFailed++;
      $display("[TB] FAIL fairness: lane2 at word %0d lane3 at word %0d, required both within 1..4", pos2, pos3);
    end

    // Asynchronous reset while a word is held and two lanes are waiting.
    doReset();
    applyStimulus(4'b0111, 64'h0000_0033_0022_0011, 0, 0);
    applyStimulus(4'b0000, 64'h0, 0, 0);
    checkModel("rst_preload");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 4'b0000, 0, 16'h0000, 2'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0000, 64'h0, 1, 0);
      checkOutput("rst_quiet", 4'b0000, 0, 16'h0000, 2'd0, 0, 0, 0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rAcc = {$urandom, $urandom};
      applyStimulus(4'($urandom & $urandom), rAcc,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      checkModel("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
